// File: rtl/qr_stream_core.sv
// Stream wrapper for the QR CORDIC engine: unpacks an input frame into the engine vector,
// runs the engine, and repacks its result onto the output stream; optional per-frame bypass.
module qr_stream_core #(
    parameter int unsigned TBITS     = 32,
    parameter int unsigned TBYTE     = 4,
    parameter int unsigned ELEM_W    = 13,
    parameter int unsigned EPW       = 2,
    parameter int unsigned IN_WORDS  = 8,
    parameter int unsigned OUT_WORDS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mode,
    input  logic [TBITS-1:0]                  isif_data_dout,
    input  logic [TBYTE-1:0]                  isif_strb_dout,
    input  logic                              isif_last_dout,
    input  logic                              isif_user_dout,
    input  logic                              isif_empty_n,
    output logic                              isif_read,
    output logic [TBITS-1:0]                  osif_data_din,
    output logic [TBYTE-1:0]                  osif_strb_din,
    output logic                              osif_last_din,
    output logic                              osif_user_din,
    input  logic                              osif_full_n,
    output logic                              osif_write,
    output logic                              eng_start,
    output logic [IN_WORDS*EPW*ELEM_W-1:0]    eng_in,
    input  logic                              eng_done,
    input  logic [OUT_WORDS*EPW*ELEM_W-1:0]   eng_out,
    output logic                              busy,
    output logic                              frame_err
);

    localparam int unsigned InW      = IN_WORDS * EPW * ELEM_W;
    localparam int unsigned OutW     = OUT_WORDS * EPW * ELEM_W;
    localparam int unsigned MaxWords = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int unsigned CW       = $clog2(MaxWords) + 1;
    localparam logic [CW-1:0] RdLast = CW'(IN_WORDS - 1);
    localparam logic [CW-1:0] WrLast = CW'(OUT_WORDS - 1);

    typedef enum logic [2:0] {StIdle, StRead, StCal, StWb, StByp} state_e;

    state_e          state_q;
    logic [CW-1:0]   rd_cnt_q, wr_cnt_q;
    logic [InW-1:0]  in_buf_q;
    logic [OutW-1:0] out_buf_q;
    logic            eng_start_q, frame_err_q, done_seen_q;
    logic [TBITS-1:0] wb_word;

    assign eng_in    = in_buf_q;
    assign eng_start = eng_start_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        wb_word = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (wr_cnt_q == CW'(j)) begin
                for (int e = 0; e < EPW; e++) begin
                    wb_word[e*ELEM_W +: ELEM_W] = out_buf_q[(j*EPW+e)*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    always_comb begin
        isif_read     = 1'b0;
        osif_write    = 1'b0;
        osif_data_din = '0;
        osif_strb_din = '0;
        osif_last_din = 1'b0;
        osif_user_din = 1'b0;
        unique case (state_q)
            StRead: isif_read = isif_empty_n;
            StWb: begin
                osif_write = osif_full_n;
                if (osif_full_n) begin
                    osif_data_din = wb_word;
                    osif_strb_din = '1;
                    osif_user_din = (wr_cnt_q == '0);
                    osif_last_din = (wr_cnt_q == WrLast);
                end
            end
            StByp: begin
                isif_read  = isif_empty_n & osif_full_n;
                osif_write = isif_empty_n & osif_full_n;
                if (osif_write) begin
                    osif_data_din = isif_data_dout;
                    osif_strb_din = isif_strb_dout;
                    osif_last_din = isif_last_dout;
                    osif_user_din = isif_user_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            in_buf_q    <= '0;
            out_buf_q   <= '0;
            eng_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mode)              state_q <= StByp;
                    else if (isif_empty_n) state_q <= StRead;
                end
                StRead: begin
                    if (isif_read) begin
                        for (int k = 0; k < IN_WORDS; k++) begin
                            if (rd_cnt_q == CW'(k)) begin
                                for (int e = 0; e < EPW; e++) begin
                                    in_buf_q[(k*EPW+e)*ELEM_W +: ELEM_W] <=
                                        isif_data_dout[e*ELEM_W +: ELEM_W];
                                end
                            end
                        end
                        // Length is set by the count alone; last only flags a mismatch.
                        frame_err_q <= (isif_last_dout != (rd_cnt_q == RdLast));
                        if (rd_cnt_q == RdLast) begin
                            rd_cnt_q    <= '0;
                            eng_start_q <= 1'b1;
                            state_q     <= StCal;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + CW'(1);
                        end
                    end
                end
                StCal: begin
                    // One settling cycle after the latch gives the two-cycle result latency.
                    if (done_seen_q) begin
                        done_seen_q <= 1'b0;
                        state_q     <= StWb;
                    end else if (eng_done) begin
                        out_buf_q   <= eng_out;
                        done_seen_q <= 1'b1;
                    end
                end
                StWb: begin
                    if (osif_write) begin
                        if (wr_cnt_q == WrLast) begin
                            wr_cnt_q <= '0;
                            state_q  <= StIdle;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                    end
                end
                StByp: begin
                    if (osif_write && isif_last_dout) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
